// File: rtl/rockets_pkg.sv
// Shared types and default constants for the rocket pool controller.
`default_nettype none

package rockets_pkg;

    typedef logic signed [10:0] coord_t;
    typedef logic signed [8:0]  speed_t;

    localparam speed_t      c_PLAYER_SPEED      = -9'sd128;
    localparam speed_t      c_ALIEN_SPEED       = 9'sd64;
    localparam int          c_COOLDOWN_FRAMES   = 8;
    localparam int          c_ALIEN_FIRE_PERIOD = 30;
    localparam int          c_CNT_W             = 16;

    // Fibonacci LFSR: taps 16,14,13,11 map to bits 15,13,12,10
    localparam logic [15:0] c_LFSR_SEED = 16'hACE1;
    localparam logic [15:0] c_LFSR_TAPS = 16'hB400;

    function automatic logic lfsr_feedback(input logic [15:0] state);
        return ^(state & c_LFSR_TAPS);
    endfunction

endpackage

`default_nettype wire

// File: rtl/rocket_slot_allocator.sv
// Active-slot bitmap with lowest-free-slot selection; one launch per clock.
`default_nettype none

module rocket_slot_allocator #(
    parameter int SLOTS = 4
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             i_set,
    input  logic [SLOTS-1:0] i_clear,
    output logic [SLOTS-1:0] o_active,
    output logic             o_found,
    output logic [SLOTS-1:0] o_free_onehot
);

    logic [SLOTS-1:0] r_active;
    logic [SLOTS-1:0] w_free;
    logic [SLOTS-1:0] w_onehot;

    // Free slots come from the registered bitmap, so a launch can never hit a slot being cleared
    assign w_free   = ~r_active;
    assign w_onehot = w_free & (~w_free + SLOTS'(1));

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_active <= '0;
        end else begin
            r_active <= (r_active & ~i_clear) | (i_set ? w_onehot : '0);
        end
    end

    assign o_active      = r_active;
    assign o_found       = |w_free;
    assign o_free_onehot = w_onehot;

endmodule

`default_nettype wire

// File: rtl/rocket_pool_controller.sv
// Player/alien rocket pool: cooldown, periodic alien fire and shared launch bus.
// Optional build macro ROCKET_ALIEN_JITTER_EN adds LFSR jitter to the alien fire period.
`default_nettype none

module rocket_pool_controller
    import rockets_pkg::*;
#(
    parameter int     PLAYER_SLOTS      = 4,
    parameter int     ALIEN_SLOTS       = 4,
    parameter speed_t PLAYER_SPEED      = c_PLAYER_SPEED,
    parameter speed_t ALIEN_SPEED       = c_ALIEN_SPEED,
    parameter int     COOLDOWN_FRAMES   = c_COOLDOWN_FRAMES,
    parameter int     ALIEN_FIRE_PERIOD = c_ALIEN_FIRE_PERIOD
) (
    input  logic                    clk,
    input  logic                    resetN,
    input  logic                    startOfFrame,
    input  logic                    player1Fire,
    input  coord_t                  PlayerTLX,
    input  coord_t                  PlayerTLY,
    input  coord_t                  AlienShooterX,
    input  coord_t                  AlienShooterY,
    input  logic [PLAYER_SLOTS-1:0] playerHit,
    input  logic [PLAYER_SLOTS-1:0] playerBorder,
    input  logic [ALIEN_SLOTS-1:0]  alienRocketHit,
    input  logic [ALIEN_SLOTS-1:0]  alienBorder,
    output speed_t                  initialSpeed,
    output coord_t                  initialX,
    output coord_t                  initialY,
    output logic [PLAYER_SLOTS-1:0] isActivePlayers,
    output logic [ALIEN_SLOTS-1:0]  isActiveAliens,
    output logic                    fireDropped
);

    localparam logic [c_CNT_W-1:0] c_COOL_LOAD  = c_CNT_W'(COOLDOWN_FRAMES);
    localparam logic [c_CNT_W-1:0] c_PERIOD_M1  = c_CNT_W'(ALIEN_FIRE_PERIOD - 1);

    logic [c_CNT_W-1:0]      r_cooldown;
    logic [c_CNT_W-1:0]      r_frame_cnt;
    logic [c_CNT_W-1:0]      w_reload;
    logic                    r_alien_pending;
    logic                    r_fire_dropped;
    coord_t                  r_x;
    coord_t                  r_y;
    speed_t                  r_speed;

    logic                    w_player_found;
    logic                    w_alien_found;
    logic [PLAYER_SLOTS-1:0] w_player_onehot;
    logic [ALIEN_SLOTS-1:0]  w_alien_onehot;
    logic                    w_accept;
    logic                    w_player_launch;
    logic                    w_alien_launch;
    logic                    w_wrap;

    assign w_accept        = player1Fire && (r_cooldown == '0);
    assign w_player_launch = w_accept && w_player_found;
    // Player owns the bus on a collision; the pending alien shot simply waits a clock
    assign w_alien_launch  = r_alien_pending && w_alien_found && !w_player_launch;
    assign w_wrap          = startOfFrame && (r_frame_cnt == '0);

`ifdef ROCKET_ALIEN_JITTER_EN
    logic [15:0] r_lfsr;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_lfsr <= c_LFSR_SEED;
        end else if (startOfFrame) begin
            r_lfsr <= {r_lfsr[14:0], lfsr_feedback(r_lfsr)};
        end
    end

    assign w_reload = c_PERIOD_M1 + c_CNT_W'(r_lfsr[3:0]);
`else
    assign w_reload = c_PERIOD_M1;
`endif

    rocket_slot_allocator #(
        .SLOTS (PLAYER_SLOTS)
    ) u_player_slots (
        .clk           (clk),
        .resetN        (resetN),
        .i_set         (w_player_launch),
        .i_clear       (playerHit | playerBorder),
        .o_active      (isActivePlayers),
        .o_found       (w_player_found),
        .o_free_onehot (w_player_onehot)
    );

    rocket_slot_allocator #(
        .SLOTS (ALIEN_SLOTS)
    ) u_alien_slots (
        .clk           (clk),
        .resetN        (resetN),
        .i_set         (w_alien_launch),
        .i_clear       (alienRocketHit | alienBorder),
        .o_active      (isActiveAliens),
        .o_found       (w_alien_found),
        .o_free_onehot (w_alien_onehot)
    );

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_cooldown      <= '0;
            r_frame_cnt     <= c_PERIOD_M1;
            r_alien_pending <= 1'b0;
            r_fire_dropped  <= 1'b0;
            r_x             <= '0;
            r_y             <= '0;
            r_speed         <= '0;
        end else begin
            r_fire_dropped <= w_accept && !w_player_found;

            if (w_player_launch) begin
                r_cooldown <= c_COOL_LOAD;
            end else if (startOfFrame && (r_cooldown != '0)) begin
                r_cooldown <= r_cooldown - 1'b1;
            end

            if (startOfFrame) begin
                r_frame_cnt <= w_wrap ? w_reload : r_frame_cnt - 1'b1;
            end

            // A fresh request outranks the clear of one just serviced
            if (w_wrap) begin
                r_alien_pending <= 1'b1;
            end else if (w_alien_launch) begin
                r_alien_pending <= 1'b0;
            end

            if (w_player_launch) begin
                r_x     <= PlayerTLX;
                r_y     <= PlayerTLY;
                r_speed <= PLAYER_SPEED;
            end else if (w_alien_launch) begin
                r_x     <= AlienShooterX;
                r_y     <= AlienShooterY;
                r_speed <= ALIEN_SPEED;
            end
        end
    end

    assign initialX     = r_x;
    assign initialY     = r_y;
    assign initialSpeed = r_speed;
    assign fireDropped  = r_fire_dropped;

endmodule

`default_nettype wire

// File: doc/rocket_pool_controller.md
Name: rocket_pool_controller

Overview:
- Parametrised successor to the single-rocket controller.
- Manages a pool of PLAYER_SLOTS player rockets and ALIEN_SLOTS alien rockets.
- Enforces a player fire cooldown, generates periodic alien fire and arbitrates one shared launch bus.
- Sits between the player/alien controllers and the per-slot single rocket movers; each mover latches initialX/initialY/initialSpeed when its isActive bit rises.

Parameters:
- PLAYER_SLOTS, 4: number of player rocket slots (1..8).
- ALIEN_SLOTS, 4: number of alien rocket slots (1..8).
- PLAYER_SPEED, -128: player launch speed, signed 9-bit, (pixels/64) per frame.
- ALIEN_SPEED, 64: alien launch speed, signed 9-bit.
- COOLDOWN_FRAMES, 8: minimum frames between accepted player shots (0 = no cooldown).
- ALIEN_FIRE_PERIOD, 30: frames between alien fire requests (>=1).

Ports:
- clk  in  1  system clock
- resetN  in  1  asynchronous active-low reset
- startOfFrame  in  1  one-cycle pulse per frame
- player1Fire  in  1  one-cycle fire request
- PlayerTLX  in  11 signed  player top-left X
- PlayerTLY  in  11 signed  player top-left Y
- AlienShooterX  in  11 signed  X of the alien selected to fire
- AlienShooterY  in  11 signed  Y of the alien selected to fire
- playerHit  in  PLAYER_SLOTS  per-slot clear: rocket hit an alien
- playerBorder  in  PLAYER_SLOTS  per-slot clear: rocket reached a border
- alienRocketHit  in  ALIEN_SLOTS  per-slot clear: hit the player or a shield
- alienBorder  in  ALIEN_SLOTS  per-slot clear: reached a border
- initialSpeed  out  9 signed  launch speed
- initialX  out  11 signed  launch X
- initialY  out  11 signed  launch Y
- isActivePlayers  out  PLAYER_SLOTS  active flag per player slot
- isActiveAliens  out  ALIEN_SLOTS  active flag per alien slot
- fireDropped  out  1  one-cycle pulse when an accepted-time request finds no free slot

Behaviour:
Reset:
- All outputs are 0.
- Cooldown counter is 0.
- Alien frame counter is ALIEN_FIRE_PERIOD-1.
- alienPending is 0.
- Reset mid-operation kills all rockets immediately.

Slot clear:
- A slot's active bit clears on the clock after its hit or border bit is high.
- A clear request to an already-inactive slot is ignored.

Player launch:
- Accepted when player1Fire=1 and cooldown counter is 0.
- If accepted and a free player slot exists: select the lowest-index free slot; on the same edge set its bit, load initialX/Y from PlayerTLX/TLY, load initialSpeed=PLAYER_SPEED, and load cooldown=COOLDOWN_FRAMES.
- If accepted and no slot is free: pulse fireDropped for one cycle; cooldown is not reloaded.
- If the cooldown counter is non-zero, the request is ignored silently.
- Latency: 1 clock from request to the isActive rise.

Cooldown:
- Decrements by 1 on each startOfFrame while non-zero; saturates at 0.

Alien fire:
- The frame counter decrements on each startOfFrame.
- At 0 it reloads to ALIEN_FIRE_PERIOD-1 and sets alienPending.
- While alienPending=1 and a free alien slot exists: launch into the lowest free slot with AlienShooterX/Y and ALIEN_SPEED, then clear alienPending.
- With no free slot, alienPending stays set (held, not dropped).

Arbitration:
- The launch bus is shared; at most one launch per clock.
- Player launch has priority. A colliding alien launch is deferred one clock; the bus values then reflect the alien launch.

Free-slot computation:
- Uses the registered active bits, so a slot cleared this cycle is reusable only from the next cycle.
- A clear and a launch in the same cycle never target the same slot.

Bus hold:
- initialX/Y/Speed hold their last launch values between launches.

Optional Feature:
- Macro: ROCKET_ALIEN_JITTER_EN.
- Defined: a 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 at reset) advances on each startOfFrame. The alien frame counter reloads to ALIEN_FIRE_PERIOD-1 + lfsr[3:0].
- Undefined: fixed period; no LFSR logic is synthesised.

Decomposition:
- Package rockets_pkg holds:
  - coord_t (logic signed [10:0]) and speed_t (logic signed [8:0]).
  - Default speed, cooldown and period constants.
  - LFSR seed and taps.
- Sub-module rocket_slot_allocator (parameter SLOTS):
  - Holds the active bitmap and takes the set-request and clear vector.
  - Outputs the active bitmap, a found flag and the one-hot lowest free slot.
  - Instantiated once for players and once for aliens.

Test Plan:
- Reset, then fire at PlayerTLX=100, PlayerTLY=400 -> next clock isActivePlayers=0001, initialX=100, initialY=400, initialSpeed=-128.
- Second fire 3 frames later -> ignored. Fire again after 8 startOfFrame pulses -> isActivePlayers=0011.
- All 4 player slots active, fire after the cooldown expires -> fireDropped pulses once; isActivePlayers stays 1111. Then playerHit=0100 -> 1011; next accepted fire sets slot 2.
- 30 startOfFrame pulses with AlienShooterX=50, AlienShooterY=80 -> isActiveAliens=0001, initialX=50, initialY=80, initialSpeed=64.
- player1Fire coinciding with an alien launch cycle -> player launches first; alien launches the following clock; bus shows alien values.
- resetN low while 3 rockets are active -> all isActive bits 0 immediately; after release, the first alien launch comes after 30 frames.
